// File: rtl/mips_bus_pkg.sv
// -----------------------------------------------------------------------------
// mips_bus_pkg
// Shared types and helpers for the MIPS bus interface unit.
//   size_t      : access size encoding on req_size (3 is illegal)
//   bus_state_t : FSM states of the bus interface unit
//   be_for      : byteenable for a given size and byte-address low bits
//   misaligned  : true when the access cannot be issued as a single bus cycle
// -----------------------------------------------------------------------------
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } bus_state_t;

  // Little-endian lane mask for an aligned access.
  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr;
      SZ_HALF: be = 4'b0011 << {addr[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Half on an odd address, word off a word boundary, or the reserved size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_bus_interface_if.sv
// -----------------------------------------------------------------------------
// mips_bus_interface_if
// Bundles the core request/response handshake and the Avalon-MM bus.
//   master : view of the bus interface unit (drives Avalon strobes and responses)
//   slave  : view of the core + memory side (drives requests, waitrequest, readdata)
// Core side  : req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata,
//              resp_valid/resp_err/resp_rdata
// Avalon side: address/read/write/writedata/byteenable/waitrequest/readdata
// -----------------------------------------------------------------------------
interface mips_bus_interface_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_bus_lane_align.sv
// -----------------------------------------------------------------------------
// mips_bus_lane_align
// Combinational lane steering.
//   st_size, st_wdata      : store size and right-justified store data
//   st_writedata           : store data replicated onto every candidate lane
//   ld_size, ld_lane       : latched load size and byte offset addr[1:0]
//   ld_signed              : sign-extend byte/half loads
//   ld_readdata            : raw Avalon readdata
//   ld_result              : right-justified, extended load value
// -----------------------------------------------------------------------------
module mips_bus_lane_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_writedata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_signed,
  input  logic [31:0] ld_readdata,
  output logic [31:0] ld_result
);

  logic [31:0] shifted_s;

  // Replicate store data so byteenable alone selects the target lane.
  always_comb begin
    st_writedata = st_wdata;
    case (st_size)
      SZ_BYTE: st_writedata = {4{st_wdata[7:0]}};
      SZ_HALF: st_writedata = {2{st_wdata[15:0]}};
      default: st_writedata = st_wdata;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    shifted_s = ld_readdata >> {ld_lane, 3'b000};
    ld_result = shifted_s;
    case (ld_size)
      SZ_BYTE: ld_result = {{24{ld_signed & shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: ld_result = {{16{ld_signed & shifted_s[15]}}, shifted_s[15:0]};
      default: ld_result = shifted_s;
    endcase
  end

endmodule

// File: rtl/mips_bus_interface.sv
// -----------------------------------------------------------------------------
// mips_bus_interface
// Bus interface unit between the MIPS datapath and an Avalon-MM memory bus.
// One request at a time: IDLE accepts, BUS holds the strobe until waitrequest
// drops, RESP pulses resp_valid for one cycle. Misaligned/illegal requests go
// straight to RESP with resp_err and never touch the bus.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : mips_bus_interface_if.master (core handshake + Avalon signals)
// Build option:
//   MIPS_BUS_TIMEOUT_EN : abort a bus cycle after TIMEOUT_CYCLES cycles of
//                         waitrequest, answering with resp_err. Without it the
//                         unit waits indefinitely.
// -----------------------------------------------------------------------------
module mips_bus_interface
  import mips_bus_pkg::*;
`ifdef MIPS_BUS_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
  input  logic                   clk,
  input  logic                   reset,
  mips_bus_interface_if.master   bus
);

  bus_state_t  state_r;
  logic        req_ready_r;
  logic        read_r;
  logic        write_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;
  logic [31:0] address_r;
  logic [31:0] writedata_r;
  logic [3:0]  byteenable_r;
  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic        signed_r;
  logic [31:0] wdata_steer_s;
  logic [31:0] load_result_s;
`ifdef MIPS_BUS_TIMEOUT_EN
  logic [15:0] timeout_cnt_r;
`endif

  // Store steering uses the live request (registered at accept); load
  // extraction uses the latched request since the core may move on.
  mips_bus_lane_align u_lane_align (
    .st_size      (bus.req_size),
    .st_wdata     (bus.req_wdata),
    .st_writedata (wdata_steer_s),
    .ld_size      (size_r),
    .ld_lane      (lane_r),
    .ld_signed    (signed_r),
    .ld_readdata  (bus.readdata),
    .ld_result    (load_result_s)
  );

  // Request FSM with registered handshake, strobes and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      address_r    <= 32'h0000_0000;
      writedata_r  <= 32'h0000_0000;
      byteenable_r <= 4'b0000;
      size_r       <= 2'b00;
      lane_r       <= 2'b00;
      signed_r     <= 1'b0;
`ifdef MIPS_BUS_TIMEOUT_EN
      timeout_cnt_r <= 16'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          if (bus.req_valid) begin
            req_ready_r <= 1'b0;
            size_r      <= bus.req_size;
            lane_r      <= bus.req_addr[1:0];
            signed_r    <= bus.req_signed;
            if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else begin
              state_r      <= ST_BUS;
              address_r    <= {bus.req_addr[31:2], 2'b00};
              byteenable_r <= be_for(bus.req_size, bus.req_addr[1:0]);
              writedata_r  <= wdata_steer_s;
              read_r       <= ~bus.req_write;
              write_r      <= bus.req_write;
`ifdef MIPS_BUS_TIMEOUT_EN
              timeout_cnt_r <= 16'd0;
`endif
            end
          end
        end

        ST_BUS: begin
          if (!bus.waitrequest) begin
            if (read_r) begin
              resp_rdata_r <= load_result_s;
            end
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            state_r      <= ST_RESP;
          end
`ifdef MIPS_BUS_TIMEOUT_EN
          // This stalled cycle is the TIMEOUT_CYCLES-th one: give up.
          else if (timeout_cnt_r == 16'(TIMEOUT_CYCLES - 1)) begin
            timeout_cnt_r <= timeout_cnt_r + 16'd1;
            read_r        <= 1'b0;
            write_r       <= 1'b0;
            resp_valid_r  <= 1'b1;
            resp_err_r    <= 1'b1;
            state_r       <= ST_RESP;
          end else begin
            timeout_cnt_r <= timeout_cnt_r + 16'd1;
          end
`endif
        end

        ST_RESP: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          req_ready_r  <= 1'b1;
          state_r      <= ST_IDLE;
        end

        default: begin
          read_r       <= 1'b0;
          write_r      <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          req_ready_r  <= 1'b1;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.address    = address_r;
  assign bus.read       = read_r;
  assign bus.write      = write_r;
  assign bus.writedata  = writedata_r;
  assign bus.byteenable = byteenable_r;

endmodule
